mem_arbiter: RTL

- Shares the SoC's single-port unified memory between the core's instruction-fetch port and its load/store port.
- Uses OBI-style req/gnt/rvalid handshakes on both requester sides and one request per cycle toward the memory.
- Sits between the core and the instruction/data memory inside the soc top.
- Arbitrates with round-robin or fixed data priority, routes read data back to the granted requester, and counts contention cycles for bring-up.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester OBI arbiter in front of the SoC's single-port unified memory.
// Fetch and load/store share one access per cycle; responses return with fixed latency 1.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_PRIO  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic [CNT_WIDTH-1:0]    conflict_cnt_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef struct packed {
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_cmd_t;

    src_e                 last_q;
    src_e                 owner_q;
    logic                 rvalid_q;
    logic [CNT_WIDTH-1:0] conflict_q;
    logic                 both_req;
    logic                 pick_data;
    mem_cmd_t             mem_cmd;

    assign both_req = instr_req_i & data_req_i;

    // On a tie, round-robin hands the slot to whoever did not win last time.
    always_comb begin
        pick_data = data_req_i;
        if (both_req && (DATA_PRIO == 0))
            pick_data = (last_q == SRC_INSTR);
    end

    // Nothing is accepted while reset is held, even with requests pending.
    assign instr_gnt_o = rst_ni & instr_req_i & ~pick_data;
    assign data_gnt_o  = rst_ni & data_req_i  &  pick_data;
    assign mem_req_o   = instr_gnt_o | data_gnt_o;

    // Idle cycles drive we=0 and be=0 so the memory cannot be disturbed.
    always_comb begin
        mem_cmd      = '0;
        mem_cmd.addr = instr_addr_i;
        if (data_gnt_o) begin
            mem_cmd.we    = data_we_i;
            mem_cmd.be    = data_be_i;
            mem_cmd.addr  = data_addr_i;
            mem_cmd.wdata = data_wdata_i;
        end else if (instr_gnt_o) begin
            mem_cmd.be    = '1;
        end
    end

    assign mem_we_o    = mem_cmd.we;
    assign mem_be_o    = mem_cmd.be;
    assign mem_addr_o  = mem_cmd.addr;
    assign mem_wdata_o = mem_cmd.wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= SRC_DATA;
            owner_q    <= SRC_INSTR;
            rvalid_q   <= 1'b0;
            conflict_q <= '0;
        end else begin
            rvalid_q <= mem_req_o;
            if (mem_req_o) begin
                last_q  <= data_gnt_o ? SRC_DATA : SRC_INSTR;
                owner_q <= data_gnt_o ? SRC_DATA : SRC_INSTR;
            end
            if (both_req && (conflict_q != '1))
                conflict_q <= conflict_q + 1'b1;
        end
    end

    assign instr_rvalid_o = rvalid_q & (owner_q == SRC_INSTR);
    assign data_rvalid_o  = rvalid_q & (owner_q == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign conflict_cnt_o = conflict_q;

endmodule
